// File: rtl/tensor_pkg.sv
// Shared encodings and defaults for the tensor sequencer: op codes, FSM states,
// latched command payload and counter/address widths.
package tensor_pkg;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned N_ELEM_DEF  = 9;
    localparam int unsigned MXU_LAT_DEF = 2;

    typedef enum logic [1:0] {
        OP_LOAD_A       = 2'b00,
        OP_LOAD_B       = 2'b01,
        OP_MATMUL       = 2'b10,
        OP_STORE_TENSOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_XFER     = 2'b01,
        ST_MXU_WAIT = 2'b10,
        ST_DONE     = 2'b11
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] base;
    } cmd_t;

endpackage

// File: rtl/elem_counter.sv
// Element / wait counter shared by the transfer and matmul-wait phases.
// Exposes its next value so the parent can register decodes of it.
module elem_counter
    import tensor_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next_c,
    output logic             tc_c
);

    always_comb begin
        count_next_c = count;
        if (clear) begin
            count_next_c = '0;
        end else if (enable) begin
            count_next_c = count + CNT_W'(1);
        end
    end

    assign tc_c = (count == last);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next_c;
        end
    end

endmodule

// File: rtl/tensor_seq_ctrl.sv
// Sequencer for tensor register-file transfers and matmul result capture.
// Latches op/base on accept, steps elements one per cycle, pulses done.
module tensor_seq_ctrl
    import tensor_pkg::*;
#(
    parameter int unsigned N_ELEM  = N_ELEM_DEF,
    parameter int unsigned MXU_LAT = MXU_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  counter_out,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              load_a,
    output logic              load_b,
    output logic              str_tensor_rez,
    output logic              store_tensor
);

    localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MXU_LAT - 1);

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic             cnt_clear, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt_last, cnt_q, cnt_next;
    logic             xfer_d;

    elem_counter u_elem_counter (
        .clk          (clk),
        .reset        (reset),
        .clear        (cnt_clear),
        .enable       (cnt_en),
        .last         (cnt_last),
        .count        (cnt_q),
        .count_next_c (cnt_next),
        .tc_c         (cnt_tc)
    );

    // Next-state, command latch and counter control
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        cnt_last  = (state_q == ST_XFER) ? XFER_LAST : WAIT_LAST;
        unique case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (start) begin
                    cmd_d.op   = op_e'(op);
                    cmd_d.base = base_addr;
                    state_d    = (op_e'(op) == OP_MATMUL) ? ST_MXU_WAIT : ST_XFER;
                end
            end
            ST_XFER, ST_MXU_WAIT: begin
                if (cnt_tc) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                cnt_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign xfer_d      = (state_d == ST_XFER);
    assign counter_out = cnt_q;

    // State register plus outputs registered from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '{op: OP_LOAD_A, base: '0};
            busy           <= 1'b0;
            done           <= 1'b0;
            dm_addr        <= '0;
            load_a         <= 1'b0;
            load_b         <= 1'b0;
            str_tensor_rez <= 1'b0;
            store_tensor   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            busy           <= (state_d != ST_IDLE);
            done           <= (state_d == ST_DONE);
            dm_addr        <= cmd_d.base + ADDR_W'(xfer_d ? cnt_next : CNT_W'(0));
            load_a         <= xfer_d && (cmd_d.op == OP_LOAD_A);
            load_b         <= xfer_d && (cmd_d.op == OP_LOAD_B);
            store_tensor   <= xfer_d && (cmd_d.op == OP_STORE_TENSOR);
            str_tensor_rez <= (state_d == ST_MXU_WAIT) && (cnt_next == WAIT_LAST);
        end
    end

endmodule

// File: doc/tensor_seq_ctrl.md
TENSOR_SEQ_CTRL -- requirements
Module: tensor_seq_ctrl

Interface
REQ-001 Parameter N_ELEM, default 9, tensor elements per transfer (3x3 of 16-bit, 144-bit tensor).
REQ-002 Parameter MXU_LAT, default 2, cycles between matmul start and result capture (1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a tensor operation; sampled only in IDLE.
REQ-006 op  input  2  operation: 00 LOAD_A, 01 LOAD_B, 10 MATMUL, 11 STORE_TENSOR.
REQ-007 base_addr  input  16  data-memory word address of element 0.
REQ-008 busy  output  1  high while an accepted operation is in progress, including its DONE cycle.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 counter_out  output  4  element index driving the tensor register idx port.
REQ-011 dm_addr  output  16  data-memory address for the current element.
REQ-012 load_a  output  1  LOAD_A control line to the register file.
REQ-013 load_b  output  1  LOAD_B control line to the register file.
REQ-014 str_tensor_rez  output  1  STR_TENSOR_REZ control line (tensor accumulator capture).
REQ-015 store_tensor  output  1  STORE_TENSOR control line (data-memory write of one element).

Function
REQ-016 FSM states SHALL be IDLE, XFER, MXU_WAIT, DONE.
REQ-017 In IDLE with start=1, op and base_addr SHALL be latched; next state XFER for ops 00/01/11, MXU_WAIT for op 10.
REQ-018 start SHALL be ignored in every state other than IDLE; latched op/base_addr SHALL not change until return to IDLE.
REQ-019 In XFER the element counter i SHALL run 0..N_ELEM-1, one element per cycle, with counter_out=i and dm_addr=base+i.
REQ-020 dm_addr SHALL wrap modulo 2^16 (base 0xFFFE, i=3 -> 0x0001).
REQ-021 In XFER exactly one of load_a/load_b/store_tensor SHALL be high, selected by latched op; data memory read is combinational, so dm_out is valid in the same cycle.
REQ-022 After element N_ELEM-1, XFER SHALL go to DONE; counter SHALL reset to 0.
REQ-023 MXU_WAIT SHALL last MXU_LAT cycles; str_tensor_rez SHALL be high in its last cycle only, then DONE.
REQ-024 DONE SHALL last one cycle with done=1, then IDLE; a start in DONE SHALL be ignored.
REQ-025 Latency: LOAD/STORE start accepted at edge 0 -> first element cycle 1, done at cycle N_ELEM+1 (10); MATMUL -> str_tensor_rez at cycle MXU_LAT, done at MXU_LAT+1.
REQ-026 In IDLE and DONE, all control lines SHALL be 0, counter_out=0, dm_addr=latched base.
REQ-027 busy SHALL be 0 in IDLE and 1 in XFER, MXU_WAIT, DONE.
REQ-028 All outputs SHALL be registered-state decodes; no combinational path from start to any output.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE regardless of state, including mid-XFER or mid-MXU_WAIT.
REQ-030 After reset: busy=0, done=0, counter_out=0, dm_addr=0, load_a=load_b=str_tensor_rez=store_tensor=0, latched op=00.
REQ-031 A start coincident with reset SHALL be discarded.

Structure
REQ-032 Package tensor_pkg SHALL hold op encodings, FSM state encoding, default N_ELEM and MXU_LAT.
REQ-033 The element/wait counter SHALL be a sub-module elem_counter (4-bit, clear, enable, terminal-count output), shared by XFER and MXU_WAIT.

Verification
REQ-034 LOAD_A base 0x0100 -> load_a high cycles 1..9, counter_out 0..8, dm_addr 0x0100..0x0108, done at cycle 10, load_b/store_tensor never high.
REQ-035 MATMUL, MXU_LAT=2 -> str_tensor_rez high only at cycle 2, done at cycle 3, busy cycles 1..3.
REQ-036 STORE_TENSOR base 0xFFFC -> dm_addr FFFC,FFFD,FFFE,FFFF,0000..0004, store_tensor 9 cycles.
REQ-037 start held high continuously with LOAD_B -> new operation accepted only in IDLE after each DONE; second op's first element 12 cycles after first accept.
REQ-038 reset asserted at element 4 of LOAD_A -> next cycle all outputs at reset values; fresh start then completes a full 9-element transfer.
REQ-039 Op/base changed during busy -> transfer uses originally latched values throughout.
